// File: rtl/nonce_scheduler_if.sv
// Hit report handshake from the nonce scheduler to the host.
// The scheduler holds hit_nonce/hit_hash stable while hit_valid is high.
interface nonce_scheduler_if;
  logic        hit_valid;
  logic        hit_ready;
  logic [31:0] hit_nonce;
  logic [31:0] hit_hash;

  modport master (output hit_valid, output hit_nonce, output hit_hash, input hit_ready);
  modport slave  (input hit_valid, input hit_nonce, input hit_hash, output hit_ready);
endinterface

// File: rtl/nonce_scheduler.sv
// Sequencing controller for the SHA-256 mining lanes: block/select round
// counters, nonce insertion strobe, per-group nonce base and hit detection.
//
// state    | meaning
// S_IDLE   | waiting for start, counters parked at 0/0
// S_RUN    | stepping select through blocks 0..2
// S_CHECK  | one cycle, block 3: evaluate lane h1 values against target
// S_REPORT | hit_valid high until the host accepts the hit
module nonce_scheduler #(
  parameter int LANES     = 4,
  parameter int ROUND_LEN = 66
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [31:0]         nonce_base,
  input  logic [31:0]         nonce_limit,
  input  logic [5:0]          zero_bits,
  input  logic [32*LANES-1:0] h1_lanes,
  output logic [1:0]          block,
  output logic [6:0]          select,
  output logic [4:0]          word_sel,
  output logic                nonce_ins,
  output logic [31:0]         lane_nonce,
  output logic                busy,
  output logic                done,
  nonce_scheduler_if.master   hit
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_REPORT} state_t;

  state_t      state, state_next;
  logic [1:0]  block_next;
  logic [6:0]  select_next;
  logic [4:0]  word_sel_next;
  logic        nonce_ins_next;
  logic [31:0] nonce_next;
  logic        done_next;
  logic        hit_load;
  logic        advance;
  logic        load_cfg;
  logic [32:0] nonce_step;

  logic [31:0] limit_q;
  logic [5:0]  zbits_q;
  logic [31:0] zmask;
  logic        hit_any;
  logic [31:0] win_nonce;
  logic [31:0] win_hash;
  logic [31:0] lane_h1;
  logic [32:0] lane_n;

  assign load_cfg   = (state == S_IDLE) && start && !stop;
  assign nonce_step = {1'b0, lane_nonce} + 33'(LANES);

  // Leading-zero target as a mask of the top zero_bits bits; 32+ means h1 must be zero.
  assign zmask = (zbits_q >= 6'd32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> zbits_q);

  // Scan high to low so the lowest qualifying lane is the one left standing.
  always_comb begin
    hit_any   = 1'b0;
    win_nonce = lane_nonce;
    win_hash  = '0;
    lane_h1   = '0;
    lane_n    = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      lane_h1 = h1_lanes[32*k +: 32];
      lane_n  = {1'b0, lane_nonce} + 33'(k);
      if (((lane_h1 & zmask) == 32'd0) && (lane_n <= {1'b0, limit_q})) begin
        hit_any   = 1'b1;
        win_nonce = lane_n[31:0];
        win_hash  = lane_h1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    block_next  = block;
    select_next = select;
    nonce_next  = lane_nonce;
    done_next   = 1'b0;
    hit_load    = 1'b0;
    advance     = 1'b0;
    case (state)
      S_IDLE: begin
        block_next  = '0;
        select_next = '0;
        if (start) begin
          state_next = S_RUN;
          nonce_next = nonce_base;
        end
      end
      S_RUN: begin
        if (select == 7'(ROUND_LEN - 1)) begin
          select_next = '0;
          if (block == 2'd2) begin
            state_next = S_CHECK;
            block_next = 2'd3;
          end else begin
            block_next = block + 2'd1;
          end
        end else begin
          select_next = select + 7'd1;
        end
      end
      S_CHECK: begin
        if (hit_any) begin
          state_next = S_REPORT;
          hit_load   = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      S_REPORT: begin
        if (hit.hit_ready) advance = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase

    // 33-bit step keeps the last group from wrapping back to nonce 0.
    if (advance) begin
      block_next  = '0;
      select_next = '0;
      if (nonce_step > {1'b0, limit_q}) begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end else begin
        state_next = S_RUN;
        nonce_next = nonce_step[31:0];
      end
    end

    if (stop) begin
      state_next  = S_IDLE;
      block_next  = '0;
      select_next = '0;
      nonce_next  = lane_nonce;
      done_next   = 1'b0;
      hit_load    = 1'b0;
    end
  end

  always_comb begin
    word_sel_next = '0;
    if (block_next == 2'd0)      word_sel_next = {1'b0, select_next[3:0]};
    else if (block_next == 2'd1) word_sel_next = {1'b1, select_next[3:0]};
    nonce_ins_next = (block_next == 2'd1) && (select_next == 7'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      block         <= '0;
      select        <= '0;
      word_sel      <= '0;
      nonce_ins     <= 1'b0;
      lane_nonce    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      limit_q       <= '0;
      zbits_q       <= '0;
      hit.hit_valid <= 1'b0;
      hit.hit_nonce <= '0;
      hit.hit_hash  <= '0;
    end else begin
      block         <= block_next;
      select        <= select_next;
      word_sel      <= word_sel_next;
      nonce_ins     <= nonce_ins_next;
      lane_nonce    <= nonce_next;
      busy          <= (state_next != S_IDLE);
      done          <= done_next;
      hit.hit_valid <= (state_next == S_REPORT);
      if (hit_load) begin
        hit.hit_nonce <= win_nonce;
        hit.hit_hash  <= win_hash;
      end
      if (load_cfg) begin
        limit_q <= nonce_limit;
        zbits_q <= zero_bits;
      end
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: group-position model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_nonce_scheduler;
  localparam int LANES     = 4;
  localparam int ROUND_LEN = 66;
  localparam int M_IDLE = 0, M_RUN = 1, M_CHECK = 2, M_REPORT = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic [31:0]         nonce_base = '0;
  logic [31:0]         nonce_limit = '0;
  logic [5:0]          zero_bits = '0;
  logic [32*LANES-1:0] h1_lanes = '0;
  logic [1:0]          block;
  logic [6:0]          select;
  logic [4:0]          word_sel;
  logic                nonce_ins;
  logic [31:0]         lane_nonce;
  logic                busy;
  logic                done;

  nonce_scheduler_if hif ();

  nonce_scheduler #(.LANES(LANES), .ROUND_LEN(ROUND_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .nonce_base(nonce_base), .nonce_limit(nonce_limit), .zero_bits(zero_bits),
    .h1_lanes(h1_lanes), .block(block), .select(select), .word_sel(word_sel),
    .nonce_ins(nonce_ins), .lane_nonce(lane_nonce), .busy(busy), .done(done),
    .hit(hif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int t0     = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_n, act, exp);
    end
  endtask

  // Model: where we are in the group (0..197 running, then check/report).
  int          m_mode = M_IDLE;
  int          m_pos = 0;
  logic [31:0] m_nonce = '0, m_limit = '0, m_hn = '0, m_hh = '0;
  logic [5:0]  m_zb = '0;
  logic        m_done = 1'b0;

  function automatic bit qualifies(input logic [31:0] h, input logic [5:0] zb);
    int  z;
    bit  seen;
    z = 0;
    seen = 0;
    if (zb >= 6'd32) return (h == 32'd0);
    for (int b = 31; b >= 0; b--) begin
      if (h[b]) seen = 1;
      if (!seen) z++;
    end
    return z >= int'(zb);
  endfunction

  always @(posedge clk) begin : model
    int          mode_n, pos_n;
    logic [31:0] nonce_n, hn_n, hh_n;
    logic        done_n, found, adv;
    mode_n = m_mode; pos_n = m_pos; nonce_n = m_nonce;
    hn_n = m_hn; hh_n = m_hh; done_n = 0; found = 0; adv = 0;
    if (rst) begin
      mode_n = M_IDLE; pos_n = 0; nonce_n = '0; hn_n = '0; hh_n = '0;
    end else if (stop) begin
      mode_n = M_IDLE; pos_n = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          mode_n = M_RUN; pos_n = 0; nonce_n = nonce_base;
          m_limit <= nonce_limit; m_zb <= zero_bits;
        end
        M_RUN: begin
          pos_n = m_pos + 1;
          if (pos_n == 3 * ROUND_LEN) mode_n = M_CHECK;
        end
        M_CHECK: begin
          for (int k = 0; k < LANES; k++)
            if (!found && qualifies(h1_lanes[32*k +: 32], m_zb) &&
                (({1'b0, m_nonce} + 33'(k)) <= {1'b0, m_limit})) begin
              found = 1; hn_n = m_nonce + 32'(k); hh_n = h1_lanes[32*k +: 32];
            end
          if (found) mode_n = M_REPORT; else adv = 1;
        end
        default: if (hif.hit_ready) adv = 1;
      endcase
      if (adv) begin
        if (({1'b0, m_nonce} + 33'(LANES)) > {1'b0, m_limit}) begin
          mode_n = M_IDLE; done_n = 1;
        end else begin
          mode_n = M_RUN; pos_n = 0; nonce_n = m_nonce + 32'(LANES);
        end
      end
    end
    m_mode <= mode_n; m_pos <= pos_n; m_nonce <= nonce_n;
    m_hn <= hn_n; m_hh <= hh_n; m_done <= done_n;
  end

  always @(negedge clk) begin : compare
    logic [1:0] eb;
    logic [6:0] es;
    logic [4:0] ew;
    logic       en;
    if (cyc_n > 0) begin
      eb = '0; es = '0; ew = '0; en = 0;
      if (m_mode == M_RUN) begin
        eb = 2'(m_pos / ROUND_LEN);
        es = 7'(m_pos % ROUND_LEN);
        if (eb < 2) ew = 5'(int'(eb) * 16 + int'(es) % 16);
        en = (m_pos == ROUND_LEN + 3);
      end else if (m_mode != M_IDLE) begin
        eb = 2'd3;
      end
      chk("block", 32'(block), 32'(eb));
      chk("select", 32'(select), 32'(es));
      chk("word_sel", 32'(word_sel), 32'(ew));
      chk("nonce_ins", 32'(nonce_ins), 32'(en));
      chk("lane_nonce", lane_nonce, m_nonce);
      chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
      chk("done", 32'(done), 32'(m_done));
      chk("hit_valid", 32'(hif.hit_valid), 32'(m_mode == M_REPORT));
      chk("hit_nonce", hif.hit_nonce, m_hn);
      chk("hit_hash", hif.hit_hash, m_hh);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic begin_search(input logic [31:0] b, input logic [31:0] l, input logic [5:0] z);
    nonce_base = b; nonce_limit = l; zero_bits = z; start = 1'b1; t0 = cyc_n;
    tick();
    start = 1'b0;
  endtask

  task automatic at_cycle(input int k);
    while (cyc_n < t0 + k) tick();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  localparam logic [32*LANES-1:0] H_PRIO =
    {32'h00FF_0000, 32'hFFFF_FFFF, 32'h00FF_0000, 32'hFFFF_FFFF};

  initial begin
    hif.hit_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_block", 32'(block), 32'd0);

    // Counter sweep: two groups, no hits.
    h1_lanes = {4{32'h8000_0001}};
    begin_search(32'd0, 32'd7, 6'd40);
    at_cycle(1);   chk("sweep_busy", 32'(busy), 32'd1);
    chk("sweep_sel0", 32'(select), 32'd0);
    at_cycle(66);  chk("sweep_sel65", 32'(select), 32'd65);
    chk("sweep_ws65", 32'(word_sel), 32'd1);
    at_cycle(67);  chk("sweep_blk1", 32'(block), 32'd1);
    chk("sweep_ws16", 32'(word_sel), 32'd16);
    at_cycle(70);  chk("sweep_nins", 32'(nonce_ins), 32'd1);
    chk("sweep_ws19", 32'(word_sel), 32'd19);
    at_cycle(199); chk("sweep_chk_blk", 32'(block), 32'd3);
    at_cycle(200); chk("sweep_nonce4", lane_nonce, 32'd4);
    at_cycle(399); chk("sweep_done", 32'(done), 32'd1);
    chk("sweep_idle", 32'(busy), 32'd0);
    at_cycle(400); chk("sweep_done_pulse", 32'(done), 32'd0);

    // Hit priority: lanes 1 and 3 qualify, lane 1 wins.
    h1_lanes = H_PRIO;
    begin_search(32'h100, 32'h107, 6'd8);
    at_cycle(200); chk("prio_valid", 32'(hif.hit_valid), 32'd1);
    chk("prio_nonce", hif.hit_nonce, 32'h101);
    chk("prio_hash", hif.hit_hash, 32'h00FF_0000);
    at_cycle(201); chk("prio_next_nonce", lane_nonce, 32'h104);
    chk("prio_resume", 32'(busy), 32'd1);
    at_cycle(400); chk("prio_nonce2", hif.hit_nonce, 32'h105);
    at_cycle(401); chk("prio_done", 32'(done), 32'd1);

    // Backpressure: hold hit_ready low for 10 cycles.
    hif.hit_ready = 1'b0;
    begin_search(32'h100, 32'h107, 6'd8);
    at_cycle(209); chk("bp_valid_held", 32'(hif.hit_valid), 32'd1);
    chk("bp_nonce", hif.hit_nonce, 32'h101);
    chk("bp_block", 32'(block), 32'd3);
    chk("bp_select", 32'(select), 32'd0);
    at_cycle(210); hif.hit_ready = 1'b1;
    at_cycle(211); chk("bp_resume_valid", 32'(hif.hit_valid), 32'd0);
    chk("bp_resume_nonce", lane_nonce, 32'h104);
    chk("bp_resume_busy", 32'(busy), 32'd1);
    at_cycle(230); do_stop();
    chk("bp_stop_busy", 32'(busy), 32'd0);

    // Range edge: lanes 2 and 3 would wrap past 0xFFFFFFFF.
    h1_lanes = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    begin_search(32'hFFFF_FFFE, 32'hFFFF_FFFF, 6'd0);
    at_cycle(200); chk("edge_nonce", hif.hit_nonce, 32'hFFFF_FFFE);
    chk("edge_hash", hif.hit_hash, 32'h1111_1111);
    at_cycle(201); chk("edge_done", 32'(done), 32'd1);
    chk("edge_busy", 32'(busy), 32'd0);
    chk("edge_lane_nonce", lane_nonce, 32'hFFFF_FFFE);

    // Target of 40 bits only accepts h1 == 0.
    h1_lanes = {32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001};
    begin_search(32'h10, 32'h20, 6'd40);
    at_cycle(200); chk("zb40_nonce", hif.hit_nonce, 32'h12);
    chk("zb40_hash", hif.hit_hash, 32'h0);
    at_cycle(201); chk("zb40_next", lane_nonce, 32'h14);
    do_stop();

    // Abort, ignored restart, start+stop in IDLE.
    h1_lanes = {4{32'h8000_0001}};
    begin_search(32'd0, 32'hFFFF, 6'd40);
    at_cycle(30);
    nonce_base = 32'h5555; start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_start_ignored", lane_nonce, 32'd0);
    at_cycle(87); chk("abort_blk", 32'(block), 32'd1);
    chk("abort_sel", 32'(select), 32'd20);
    do_stop();
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_sel0", 32'(select), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_idle", 32'(busy), 32'd0);
    tick();
    chk("startstop_still", 32'(busy), 32'd0);

    // Reset while a hit is pending.
    h1_lanes = H_PRIO;
    hif.hit_ready = 1'b0;
    begin_search(32'h100, 32'h107, 6'd8);
    at_cycle(205); chk("rst_pre_valid", 32'(hif.hit_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(hif.hit_valid), 32'd0);
    chk("rst_hit_nonce", hif.hit_nonce, 32'd0);
    chk("rst_hit_hash", hif.hit_hash, 32'd0);
    chk("rst_lane_nonce", lane_nonce, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_block", 32'(block), 32'd0);
    chk("rst_word_sel", 32'(word_sel), 32'd0);
    hif.hit_ready = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
